// File: rtl/board_reset_button_ctrl.sv
// Board reset sequencer and push-button conditioner (sync, debounce, press pulses, stretched reset).
// Optional macro BOARD_BUTTON_RESET_EN makes a debounced press of button RESET_BTN a reset trigger.
module board_reset_button_ctrl #(
    parameter int N_BUTTONS         = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int RESET_HOLD_CYCLES = 1024,
    parameter int RESET_BTN         = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_n,
    input  logic                 sys_rst_req,
    output logic [N_BUTTONS-1:0] btn,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic                 sys_rst_n,
    output logic [7:0]           rst_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          db_cnt;
        logic                   btn_q;
        logic                   press_q;
        logic                   s;

        assign s            = ~sync_q[SYNC_STAGES-1];
        assign btn[i]       = btn_q;
        assign btn_press[i] = press_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q  <= '1;
                db_cnt  <= '0;
                btn_q   <= 1'b0;
                press_q <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_n[i]};
                press_q <= 1'b0;
                // Any cycle agreeing with the current level restarts qualification.
                if (s == btn_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    btn_q   <= s;
                    press_q <= s;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

    logic trigger;
`ifdef BOARD_BUTTON_RESET_EN
    assign trigger = sys_rst_req | btn_press[RESET_BTN];
`else
    assign trigger = sys_rst_req;
`endif

    typedef enum logic {StHold, StRun} state_t;
    state_t        state_q;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StHold;
            hold_cnt  <= '0;
            sys_rst_n <= 1'b0;
            rst_count <= 8'd0;
        end else begin
            case (state_q)
                StHold: begin
                    sys_rst_n <= 1'b0;
                    // A trigger at terminal count wins and restarts the hold window.
                    if (trigger) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_q   <= StRun;
                        sys_rst_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                StRun: begin
                    sys_rst_n <= 1'b1;
                    if (trigger) begin
                        state_q   <= StHold;
                        hold_cnt  <= '0;
                        sys_rst_n <= 1'b0;
                        if (rst_count != 8'hFF) rst_count <= rst_count + 8'd1;
                    end
                end
                default: state_q <= StHold;
            endcase
        end
    end

endmodule

// File: tb/tb_board_reset_button_ctrl.sv
// Self-checking bench for board_reset_button_ctrl: directed vector table, corner sequences,
// and randomized stimulus against an edge-history reference model.
module tb_board_reset_button_ctrl;
    localparam int NB = 4;
    localparam int S  = 2;
    localparam int D  = 8;
    localparam int H  = 16;
    localparam int RB = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_n = '1;
    logic          sys_rst_req = 1'b0;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_press;
    logic          sys_rst_n;
    logic [7:0]    rst_count;

    board_reset_button_ctrl #(
        .N_BUTTONS        (NB),
        .SYNC_STAGES      (S),
        .DEBOUNCE_CYCLES  (D),
        .RESET_HOLD_CYCLES(H),
        .RESET_BTN        (RB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .sys_rst_req(sys_rst_req),
        .btn        (btn),
        .btn_press  (btn_press),
        .sys_rst_n  (sys_rst_n),
        .rst_count  (rst_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_model = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of sampled raw inputs, indexed by edge number since reset.
    logic [NB-1:0] raw_hist [0:8191];
    int            k;
    int            last_flip [NB];
    logic [NB-1:0] m_btn, m_press;
    int            m_l, m_cnt;
    logic          m_rstn;

    function automatic logic [NB-1:0] raw_at(input int idx);
        if (idx < 1) return '1;
        return raw_hist[idx];
    endfunction

    task automatic model_reset();
        k = 0; m_btn = '0; m_press = '0; m_l = 0; m_cnt = 0; m_rstn = 1'b0;
        for (int i = 0; i < NB; i++) last_flip[i] = 0;
    endtask

    task automatic model_edge(input logic [NB-1:0] bn, input logic rq);
        logic          trig;
        logic [NB-1:0] newp;
        logic [NB-1:0] r;
        bit            flip;
        k++;
        raw_hist[k] = bn;
        trig = rq;
`ifdef BOARD_BUTTON_RESET_EN
        trig = trig | m_press[RB];
`endif
        if (trig) begin
            if (m_rstn && m_cnt < 255) m_cnt++;
            m_l = k;
        end
        m_rstn = ((k - m_l) >= H);
        newp = '0;
        for (int i = 0; i < NB; i++) begin
            // Level flips when the last D edges since the previous flip all saw the new level.
            flip = 1'b1;
            for (int j = 0; j < D; j++) begin
                r = raw_at(k - j - S);
                if ((k - j) <= last_flip[i]) flip = 1'b0;
                else if ((~r[i]) == m_btn[i]) flip = 1'b0;
            end
            if (flip) begin
                newp[i]      = ~m_btn[i];
                m_btn[i]     = ~m_btn[i];
                last_flip[i] = k;
            end
        end
        m_press = newp;
    endtask

    task automatic compare_model();
        check("m_btn", int'(btn), int'(m_btn));
        check("m_press", int'(btn_press), int'(m_press));
        check("m_rstn", int'(sys_rst_n), int'(m_rstn));
        check("m_cnt", int'(rst_count), m_cnt);
    endtask

    // Called at posedge+1: drive, take one edge, update model, sample after the edge.
    task automatic step(input logic [NB-1:0] bn, input logic rq);
        btn_n = bn;
        sys_rst_req = rq;
        @(posedge clk);
        model_edge(bn, rq);
        #1;
        if (chk_model) compare_model();
    endtask

    typedef struct {
        logic [NB-1:0] bn;
        logic          rq;
        int            cyc;
        logic [NB-1:0] e_btn;
        logic [NB-1:0] e_press;
        logic          e_rstn;
        int            e_cnt;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int            n;
        logic [NB-1:0] lvl;
        int            dur [NB];
        int            burst;
        logic          rq;

        tbl[0]  = '{4'hF, 1'b0, 15, 4'h0, 4'h0, 1'b0, 0};  // through edge 15
        tbl[1]  = '{4'hF, 1'b0, 1,  4'h0, 4'h0, 1'b1, 0};  // edge 16 releases
        tbl[2]  = '{4'hB, 1'b0, 9,  4'h0, 4'h0, 1'b1, 0};  // btn 2 pressed from edge 17
        tbl[3]  = '{4'hB, 1'b0, 1,  4'h4, 4'h4, 1'b1, 0};  // edge 26
        tbl[4]  = '{4'hB, 1'b0, 1,  4'h4, 4'h0, 1'b1, 0};
        tbl[5]  = '{4'hB, 1'b1, 1,  4'h4, 4'h0, 1'b0, 1};  // soft request in RUN at edge 28
        tbl[6]  = '{4'hB, 1'b0, 10, 4'h4, 4'h0, 1'b0, 1};  // hold count 10
        tbl[7]  = '{4'hB, 1'b1, 1,  4'h4, 4'h0, 1'b0, 1};  // retrigger in HOLD at edge 39
        tbl[8]  = '{4'hB, 1'b0, 15, 4'h4, 4'h0, 1'b0, 1};
        tbl[9]  = '{4'hB, 1'b0, 1,  4'h4, 4'h0, 1'b1, 1};  // edge 55
        tbl[10] = '{4'hF, 1'b0, 9,  4'h4, 4'h0, 1'b1, 1};  // release btn 2 from edge 56
        tbl[11] = '{4'hF, 1'b0, 1,  4'h0, 4'h0, 1'b1, 1};  // edge 65, no pulse
        tbl[12] = '{4'hD, 1'b0, 7,  4'h0, 4'h0, 1'b1, 1};  // btn 1 bouncing
        tbl[13] = '{4'hF, 1'b0, 1,  4'h0, 4'h0, 1'b1, 1};
        tbl[14] = '{4'hD, 1'b0, 7,  4'h0, 4'h0, 1'b1, 1};
        tbl[15] = '{4'hF, 1'b0, 1,  4'h0, 4'h0, 1'b1, 1};
        tbl[16] = '{4'hF, 1'b0, 10, 4'h0, 4'h0, 1'b1, 1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_btn", int'(btn), 0);
        check("rst_press", int'(btn_press), 0);
        check("rst_sys_rst_n", int'(sys_rst_n), 0);
        check("rst_count0", int'(rst_count), 0);
        rst = 1'b0;

        for (int v = 0; v < 17; v++) begin
            for (int c = 0; c < tbl[v].cyc; c++) step(tbl[v].bn, tbl[v].rq);
            check($sformatf("vec%0d_btn", v), int'(btn), int'(tbl[v].e_btn));
            check($sformatf("vec%0d_press", v), int'(btn_press), int'(tbl[v].e_press));
            check($sformatf("vec%0d_rstn", v), int'(sys_rst_n), int'(tbl[v].e_rstn));
            check($sformatf("vec%0d_cnt", v), int'(rst_count), tbl[v].e_cnt);
        end

        // Button 0 press: latency, pulse, and configuration-dependent reset trigger.
        n = 0;
        do begin
            step(4'hE, 1'b0);
            n++;
        end while (!btn[0] && n < 20);
        check("btn0_latency", n, 10);
        check("btn0_press", int'(btn_press), 1);
        check("btn0_rstn_before", int'(sys_rst_n), 1);
        step(4'hE, 1'b0);
        check("btn0_press_gone", int'(btn_press), 0);
`ifdef BOARD_BUTTON_RESET_EN
        check("btn0_rstn_after", int'(sys_rst_n), 0);
        check("btn0_cnt_after", int'(rst_count), 2);
`else
        check("btn0_rstn_after", int'(sys_rst_n), 1);
        check("btn0_cnt_after", int'(rst_count), 1);
`endif

        // Asynchronous reset in the middle of a hold sequence.
        step(4'hE, 1'b1);
        repeat (4) step(4'hE, 1'b0);
        check("pre_rst_btn", int'(btn), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_btn", int'(btn), 0);
        check("mid_rst_press", int'(btn_press), 0);
        check("mid_rst_rstn", int'(sys_rst_n), 0);
        check("mid_rst_cnt", int'(rst_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized phase, checked every cycle against the model.
        chk_model = 1'b1;
        lvl = '1;
        for (int i = 0; i < NB; i++) dur[i] = 0;
        burst = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (dur[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    dur[i] = int'($urandom_range(1, 14));
                end
                dur[i]--;
            end
            if (burst > 0) burst--;
            else if ($urandom_range(0, 299) == 0) burst = int'($urandom_range(2, 30));
            rq = (burst > 0) || ($urandom_range(0, 79) == 0);
            step(lvl, rq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
